// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the instruction RAM address, rebuilds one/two-word instructions, offers them on valid/ready.
// Optional ENDOP halt support is enabled by defining IFETCH_HALT_EN.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'd0,
    parameter logic [15:0] OP_LDAC  = 16'd5,
    parameter logic [15:0] OP_STAC  = 16'd7,
    parameter logic [15:0] OP_LDA   = 16'd9,
    parameter logic [15:0] OP_LDB   = 16'd14,
    parameter logic [15:0] OP_LDC   = 16'd19,
    parameter logic [15:0] OP_STC   = 16'd24,
    parameter logic [15:0] OP_JUMP  = 16'd46,
    parameter logic [15:0] OP_JPNZ  = 16'd48,
    parameter logic [15:0] OP_ENDOP = 16'd51,
    parameter logic [15:0] OP_JPPZ  = 16'd62
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] iram_addr,
    input  logic [15:0] iram_data,
    input  logic        redirect_en,
    input  logic [15:0] redirect_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_opcode,
    output logic [15:0] instr_operand,
    output logic        instr_has_arg,
    output logic [15:0] instr_pc,
    output logic        halted
);

`ifdef IFETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    localparam int N_TWO_WORD = 9;
    localparam logic [15:0] TWO_WORD_OPS [N_TWO_WORD] = '{
        OP_LDAC, OP_STAC, OP_LDA, OP_LDB, OP_LDC, OP_STC, OP_JUMP, OP_JPNZ, OP_JPPZ
    };

    typedef enum logic [2:0] {S_BOOT, S_OP, S_ARG, S_OUT, S_HALT} state_t;

    state_t      state_reg;
    logic [15:0] pc_reg;
    logic [15:0] next_pc_reg;
    logic [15:0] opcode_reg;
    logic [15:0] operand_reg;
    logic [15:0] instr_pc_reg;
    logic        valid_reg;
    logic        has_arg_reg;
    logic        halted_reg;

    logic [N_TWO_WORD-1:0] op_match;
    logic                  two_word;

    genvar gi;
    generate
        for (gi = 0; gi < N_TWO_WORD; gi++) begin : g_decode
            assign op_match[gi] = (iram_data == TWO_WORD_OPS[gi]);
        end
    endgenerate

    assign two_word = |op_match;

    // Redirect steers the RAM in the same cycle so the new opcode arrives in S_OP.
    always_comb begin
        iram_addr = pc_reg;
        if (redirect_en) begin
            iram_addr = redirect_addr;
        end else begin
            case (state_reg)
                S_BOOT:  iram_addr = pc_reg;
                S_OP:    iram_addr = pc_reg + 16'd1;
                S_ARG:   iram_addr = pc_reg + 16'd2;
                S_OUT:   iram_addr = next_pc_reg;
                S_HALT:  iram_addr = pc_reg;
                default: iram_addr = pc_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_BOOT;
            pc_reg       <= RESET_PC;
            next_pc_reg  <= RESET_PC;
            opcode_reg   <= 16'd0;
            operand_reg  <= 16'd0;
            instr_pc_reg <= 16'd0;
            valid_reg    <= 1'b0;
            has_arg_reg  <= 1'b0;
            halted_reg   <= 1'b0;
        end else if (redirect_en) begin
            // Any held or half-built instruction is dropped, even if accepted this cycle.
            state_reg  <= S_OP;
            pc_reg     <= redirect_addr;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_BOOT: state_reg <= S_OP;
                S_OP: begin
                    opcode_reg   <= iram_data;
                    instr_pc_reg <= pc_reg;
                    has_arg_reg  <= two_word;
                    operand_reg  <= 16'd0;
                    if (two_word) begin
                        state_reg <= S_ARG;
                    end else begin
                        next_pc_reg <= pc_reg + 16'd1;
                        valid_reg   <= 1'b1;
                        state_reg   <= S_OUT;
                    end
                end
                S_ARG: begin
                    operand_reg <= iram_data;
                    next_pc_reg <= pc_reg + 16'd2;
                    valid_reg   <= 1'b1;
                    state_reg   <= S_OUT;
                end
                S_OUT: begin
                    if (instr_ready) begin
                        valid_reg <= 1'b0;
                        pc_reg    <= next_pc_reg;
                        if (HALT_EN && opcode_reg == OP_ENDOP) begin
                            state_reg  <= S_HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg <= S_OP;
                        end
                    end
                end
                S_HALT:  state_reg <= S_HALT;
                default: state_reg <= S_BOOT;
            endcase
        end
    end

    assign instr_valid   = valid_reg;
    assign instr_opcode  = opcode_reg;
    assign instr_operand = operand_reg;
    assign instr_has_arg = has_arg_reg;
    assign instr_pc      = instr_pc_reg;
    assign halted        = halted_reg & HALT_EN;

endmodule
